// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding and widths for the frame capture block
package capture_pkg;

  localparam int CSUM_W = 24;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2,
    ST_CLOSE = 2'd3
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - ping-pong frame store: one write port, one registered read port
// The write bank is selected by i_wr_bank; reads always come from the other bank.
module capture_ram
  import capture_pkg::*;
#(
  parameter int DATA_WIDH = 8,
  parameter int DEPTH     = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_bank,
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [DATA_WIDH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [DATA_WIDH-1:0] o_rd_data
);

  localparam int                MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_WIDH-1:0] r_bank0 [DEPTH];
  logic [DATA_WIDH-1:0] r_bank1 [DEPTH];
  logic [DATA_WIDH-1:0] r_rd_data;

  logic [MEM_AW-1:0] w_wr_idx;
  logic [MEM_AW-1:0] w_rd_idx;
  logic              w_wr_ok;
  logic              w_rd_in_range;

  assign w_wr_idx      = i_wr_addr[MEM_AW-1:0];
  assign w_rd_idx      = i_rd_addr[MEM_AW-1:0];
  assign w_wr_ok       = i_we && (i_wr_addr < DEPTH_A);
  assign w_rd_in_range = (i_rd_addr < DEPTH_A);

  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      if (i_wr_bank) begin
        r_bank1[w_wr_idx] <= i_wr_data;
      end else begin
        r_bank0[w_wr_idx] <= i_wr_data;
      end
    end
  end

  // Addresses past the frame read as zero rather than aliasing into the array.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (!w_rd_in_range) begin
      r_rd_data <= '0;
    end else if (i_wr_bank) begin
      r_rd_data <= r_bank0[w_rd_idx];
    end else begin
      r_rd_data <= r_bank1[w_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/frame_capture.sv
// rtl/frame_capture.sv - captures fs/hs framed video into a ping-pong store
// Good frames swap banks and publish checksum/count; bad frames only pulse frame_err.
module frame_capture
  import capture_pkg::*;
#(
  parameter int DATA_WIDH = 8,
  parameter int HANG_NUM  = 32,
  parameter int LIE_NUM   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fs,
  input  logic                 hs,
  input  logic [DATA_WIDH-1:0] data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_WIDH-1:0] rd_data,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [CSUM_W-1:0]    checksum,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam logic [ADDR_W-1:0] ROWS = ADDR_W'(HANG_NUM);
  localparam logic [ADDR_W-1:0] COLS = ADDR_W'(LIE_NUM);

  cap_state_t        r_state;
  logic              r_fs_d;
  logic              r_hs_d;
  logic              r_edge_ok;
  logic              r_rise_pend;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_base;
  logic [CSUM_W-1:0] r_sum;
  logic              r_err;
  logic              r_wr_bank;
  logic              r_frame_done;
  logic              r_frame_err;
  logic [CSUM_W-1:0] r_checksum;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic              w_fs_rise;
  logic              w_fs_fall;
  logic              w_hs_fall;
  logic              w_start;
  logic              w_pix;
  logic              w_in_range;
  logic              w_we;
  logic              w_good;
  logic [ADDR_W-1:0] w_wr_addr;

  // r_edge_ok masks the first cycle after reset so a frame already under way is not mistaken for a new one.
  assign w_fs_rise  = r_edge_ok && fs && !r_fs_d;
  assign w_fs_fall  = !fs && r_fs_d;
  assign w_hs_fall  = !hs && r_hs_d;
  assign w_start    = w_fs_rise || (r_rise_pend && fs);
  assign w_pix      = ((r_state == ST_FRAME) || (r_state == ST_LINE)) && fs && hs;
  assign w_in_range = (r_col < COLS) && (r_row < ROWS);
  assign w_we       = w_pix && w_in_range;
  assign w_wr_addr  = r_base + r_col;
  assign w_good     = (r_row == ROWS) && !r_err;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state      <= ST_IDLE;
      r_fs_d       <= 1'b0;
      r_hs_d       <= 1'b0;
      r_edge_ok    <= 1'b0;
      r_rise_pend  <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_base       <= '0;
      r_sum        <= '0;
      r_err        <= 1'b0;
      r_wr_bank    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_checksum   <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_fs_d       <= fs;
      r_hs_d       <= hs;
      r_edge_ok    <= 1'b1;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rise_pend <= 1'b0;
          if (w_start) begin
            r_state <= ST_FRAME;
            r_row   <= '0;
            r_col   <= '0;
            r_base  <= '0;
            r_sum   <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_FRAME: begin
          if (w_fs_fall) begin
            r_state <= ST_CLOSE;
          end else if (w_pix) begin
            r_state <= ST_LINE;
          end
        end
        ST_LINE: begin
          // A line close is honoured even when fs drops in the same cycle.
          if (w_hs_fall) begin
            r_row   <= r_row + ADDR_W'(1);
            r_col   <= '0;
            r_base  <= r_base + COLS;
            if (r_col != COLS) begin
              r_err <= 1'b1;
            end
            r_state <= fs ? ST_FRAME : ST_CLOSE;
          end else if (w_fs_fall) begin
            r_state <= ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          r_rise_pend <= w_fs_rise;
          r_state     <= ST_IDLE;
          if (w_good) begin
            r_frame_done <= 1'b1;
            r_wr_bank    <= !r_wr_bank;
            r_checksum   <= r_sum;
            r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
          end else begin
            r_frame_err  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_pix) begin
        if (w_in_range) begin
          r_col <= r_col + ADDR_W'(1);
          r_sum <= r_sum + CSUM_W'(data);
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  capture_ram #(
    .DATA_WIDH (DATA_WIDH),
    .DEPTH     (HANG_NUM * LIE_NUM)
  ) u_ram (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_wr_bank (r_wr_bank),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign checksum   = r_checksum;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_frame_capture.sv
// tb/tb_frame_capture.sv - self-checking bench for frame_capture
module tb_frame_capture;

  localparam int DW = 8;
  localparam int HN = 32;
  localparam int LN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs;
  logic        hs;
  logic [7:0]  data;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic        frame_done;
  logic        frame_err;
  logic [23:0] checksum;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  frame_capture #(
    .DATA_WIDH (DW),
    .HANG_NUM  (HN),
    .LIE_NUM   (LN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fs         (fs),
    .hs         (hs),
    .data       (data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .checksum   (checksum),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    string name;
    int    n_lines;
    int    odd_line;
    int    odd_len;
    bit    together;
    int    rst_line;
    int    mode;
    int    exp_done;
    int    exp_err;
    int    exp_cnt;
    int    exp_csum;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int err_seen = 0;

  logic [7:0]  pix [40][40];
  int          line_len [40];
  int          n_lines;
  logic [7:0]  img [1024];
  bit          img_valid = 1'b0;
  logic [23:0] m_csum = '0;
  int          m_cnt = 0;
  int          last_ra = -1;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, int nl, int ol, int olen, bit tog, int rl, int md,
                              int ed, int ee, int ec, int ecs);
    vec_t v;
    v.name = nm; v.n_lines = nl; v.odd_line = ol; v.odd_len = olen; v.together = tog;
    v.rst_line = rl; v.mode = md; v.exp_done = ed; v.exp_err = ee; v.exp_cnt = ec;
    v.exp_csum = ecs;
    return v;
  endfunction

  task automatic set_pattern(input int mode);
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 40; c++) begin
        case (mode)
          0:       pix[r][c] = 8'((r * 32 + c) & 255);
          1:       pix[r][c] = 8'($urandom);
          2:       pix[r][c] = 8'((r + c) & 255);
          default: pix[r][c] = 8'hFF;
        endcase
      end
    end
  endtask

  task automatic set_shape(input int nl);
    n_lines = nl;
    for (int r = 0; r < 40; r++) line_len[r] = LN;
  endtask

  function automatic bit frame_good();
    if (n_lines != HN) return 1'b0;
    for (int r = 0; r < HN; r++) begin
      if (line_len[r] != LN) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [23:0] model_sum();
    longint s;
    s = 0;
    for (int r = 0; r < HN; r++) begin
      for (int c = 0; c < LN; c++) s += longint'(pix[r][c]);
    end
    return 24'(s);
  endfunction

  task automatic commit();
    for (int r = 0; r < HN; r++) begin
      for (int c = 0; c < LN; c++) img[r * LN + c] = pix[r][c];
    end
    m_csum = model_sum();
    m_cnt = (m_cnt + 1) & 16'hFFFF;
    img_valid = 1'b1;
  endtask

  function automatic logic [7:0] exp_rd(input int a);
    if (a >= HN * LN) return 8'd0;
    return img[a];
  endfunction

  task automatic read_step(input bit en);
    if (en && last_ra >= 0) check("rd_data", 64'(rd_data), 64'(exp_rd(last_ra)));
    if (en) begin
      last_ra = int'($urandom_range(0, 1100));
      rd_addr = 11'(last_ra);
    end else begin
      last_ra = -1;
    end
  endtask

  task automatic step(input bit en);
    @(negedge clk);
    read_step(en);
  endtask

  task automatic idle_reads(input int n);
    last_ra = -1;
    repeat (n) step(img_valid);
    last_ra = -1;
  endtask

  task automatic drive_frame(input int lead, input bit together, input int gap, input int post,
                             input int rst_line, input bit rd_en);
    bit e;
    e = rd_en;
    last_ra = -1;
    fs = 1'b1; hs = 1'b0; data = '0;
    repeat (lead) step(e);
    for (int r = 0; r < n_lines; r++) begin
      if (r == rst_line) begin
        e = 1'b0;
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        step(1'b0);
        rst_n = 1'b0;
      end
      for (int c = 0; c < line_len[r]; c++) begin
        hs = 1'b1;
        data = pix[r][c];
        step(e);
      end
      if (together && r == n_lines - 1) begin
        fs = 1'b0; hs = 1'b0; data = '0;
      end else begin
        hs = 1'b0; data = '0;
        repeat (gap) step(e);
      end
    end
    fs = 1'b0; hs = 1'b0;
    repeat (post) step(1'b0);
  endtask

  vec_t vecs [6];

  initial begin
    int d0, e0, kind, gap;
    bit good, tog;

    vecs[0] = mk("good_pattern", 32, -1, 0,  1'b0, -1, 0, 1, 0, 1, 130560);
    vecs[1] = mk("short_line",   32,  7, 31, 1'b0, -1, 1, 0, 1, 1, 130560);
    vecs[2] = mk("extra_line",   33, -1, 0,  1'b0, -1, 1, 0, 1, 1, 130560);
    vecs[3] = mk("fall_together",32, -1, 0,  1'b1, -1, 2, 1, 0, 2, 31744);
    vecs[4] = mk("reset_mid",    32, -1, 0,  1'b0, 10, 0, 0, 0, 0, 0);
    vecs[5] = mk("after_reset",  32, -1, 0,  1'b0, -1, 3, 1, 0, 1, 261120);

    rst_n = 1'b1; fs = 1'b0; hs = 1'b0; data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_done", 64'(frame_done), 64'd0);
    check("reset_err", 64'(frame_err), 64'd0);
    check("reset_checksum", 64'(checksum), 64'd0);
    check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      set_pattern(vecs[i].mode);
      set_shape(vecs[i].n_lines);
      if (vecs[i].odd_line >= 0) line_len[vecs[i].odd_line] = vecs[i].odd_len;
      d0 = done_seen; e0 = err_seen;
      drive_frame(2, vecs[i].together, 5, 4, vecs[i].rst_line,
                  img_valid && (vecs[i].rst_line < 0));
      check({vecs[i].name, "_done"}, 64'(done_seen - d0), 64'(vecs[i].exp_done));
      check({vecs[i].name, "_err"}, 64'(err_seen - e0), 64'(vecs[i].exp_err));
      check({vecs[i].name, "_frame_cnt"}, 64'(frame_cnt), 64'(vecs[i].exp_cnt));
      check({vecs[i].name, "_checksum"}, 64'(checksum), 64'(vecs[i].exp_csum));
      if (vecs[i].rst_line >= 0) begin
        img_valid = 1'b0; m_cnt = 0; m_csum = '0;
      end else if (frame_good()) begin
        commit();
      end
      idle_reads(20);
      if (i <= 1) begin
        rd_addr = 11'd33;
        @(negedge clk);
        check("rd_addr_33", 64'(rd_data), 64'd33);
      end
    end

    // back-to-back good frames with a two-cycle fs gap
    d0 = done_seen; e0 = err_seen;
    set_pattern(1); set_shape(32);
    drive_frame(2, 1'b0, 5, 2, -1, img_valid);
    commit();
    set_pattern(1); set_shape(32);
    drive_frame(2, 1'b0, 5, 4, -1, 1'b1);
    check("b2b_done", 64'(done_seen - d0), 64'd2);
    check("b2b_err", 64'(err_seen - e0), 64'd0);
    commit();
    check("b2b_frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    check("b2b_checksum", 64'(checksum), 64'(m_csum));
    idle_reads(20);

    for (int k = 0; k < 6; k++) begin
      kind = int'($urandom_range(0, 4));
      gap = int'($urandom_range(1, 6));
      tog = 1'b0;
      set_pattern(1); set_shape(32);
      case (kind)
        1: line_len[$urandom_range(0, 31)] = int'($urandom_range(20, 31));
        2: line_len[$urandom_range(0, 31)] = int'($urandom_range(33, 35));
        3: n_lines = ($urandom_range(0, 1) == 1) ? 33 : 31;
        4: tog = 1'b1;
        default: ;
      endcase
      good = frame_good();
      d0 = done_seen; e0 = err_seen;
      drive_frame(2, tog, gap, 4, -1, img_valid);
      check("rand_done", 64'(done_seen - d0), 64'(good));
      check("rand_err", 64'(err_seen - e0), 64'(!good));
      if (good) commit();
      check("rand_frame_cnt", 64'(frame_cnt), 64'(m_cnt));
      check("rand_checksum", 64'(checksum), 64'(m_csum));
      idle_reads(16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
